// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Brief    : 4x4 matrix keypad scanner with synchronized, debounced press/release
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
    parameter int SCAN_DIV     = 10000,
    parameter int DEBOUNCE_CNT = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_cols,
    output logic [3:0] o_rows,
    output logic [3:0] o_key,
    output logic       o_key_valid,
    output logic       o_key_held
);

    localparam int c_MAX_PARAM = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
    localparam int c_CNT_W     = (c_MAX_PARAM > 1) ? $clog2(c_MAX_PARAM) : 1;

    localparam logic [c_CNT_W-1:0] c_SLOT_LAST = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_DB_LAST   = c_CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = '1;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    logic [3:0]         r_cs_meta;
    logic [3:0]         r_cs;
    state_t             r_state;
    logic [1:0]         r_row_idx;
    logic [3:0]         r_rows;
    logic [c_CNT_W-1:0] r_div_cnt;
    logic [c_CNT_W-1:0] r_db_cnt;
    logic [3:0]         r_pat;
    logic [1:0]         r_col;
    logic [3:0]         r_key;
    logic               r_key_valid;
    logic               r_key_held;

    logic [3:0]         w_low;
    logic               w_single;
    logic [1:0]         w_col;
    logic               w_all_high;

    function automatic logic [c_CNT_W-1:0] f_sat_inc(input logic [c_CNT_W-1:0] v);
        return (v == c_CNT_MAX) ? v : v + c_CNT_ONE;
    endfunction

    function automatic logic [3:0] f_key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] k;
        case ({row, col})
            4'h0: k = 4'h1;
            4'h1: k = 4'h2;
            4'h2: k = 4'h3;
            4'h3: k = 4'hA;
            4'h4: k = 4'h4;
            4'h5: k = 4'h5;
            4'h6: k = 4'h6;
            4'h7: k = 4'hB;
            4'h8: k = 4'h7;
            4'h9: k = 4'h8;
            4'hA: k = 4'h9;
            4'hB: k = 4'hC;
            4'hC: k = 4'hE;
            4'hD: k = 4'h0;
            4'hE: k = 4'hF;
            default: k = 4'hD;
        endcase
        return k;
    endfunction

    // Columns are asynchronous to clk; only r_cs is used beyond this point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_meta <= 4'hF;
            r_cs      <= 4'hF;
        end else begin
            r_cs_meta <= i_cols;
            r_cs      <= r_cs_meta;
        end
    end

    assign w_low      = ~r_cs;
    assign w_single   = (w_low != 4'd0) && ((w_low & (w_low - 4'd1)) == 4'd0);
    assign w_all_high = (r_cs == 4'hF);

    always_comb begin
        w_col = 2'd0;
        case (w_low)
            4'b0010: w_col = 2'd1;
            4'b0100: w_col = 2'd2;
            4'b1000: w_col = 2'd3;
            default: w_col = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SCAN;
            r_row_idx   <= 2'd0;
            r_rows      <= 4'b1110;
            r_div_cnt   <= '0;
            r_db_cnt    <= '0;
            r_pat       <= 4'hF;
            r_col       <= 2'd0;
            r_key       <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            case (r_state)
                SCAN: begin
                    if (r_div_cnt >= c_SLOT_LAST) begin
                        r_div_cnt <= '0;
                        if (w_single) begin
                            r_state  <= DEBOUNCE;
                            r_pat    <= r_cs;
                            r_col    <= w_col;
                            r_db_cnt <= '0;
                        end else begin
                            r_row_idx <= r_row_idx + 2'd1;
                            r_rows    <= {r_rows[2:0], r_rows[3]};
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + c_CNT_ONE;
                    end
                end
                DEBOUNCE: begin
                    if (r_cs == r_pat) begin
                        if (r_db_cnt >= c_DB_LAST) begin
                            r_state     <= HELD;
                            r_key       <= f_key_map(r_row_idx, r_col);
                            r_key_valid <= 1'b1;
                            r_key_held  <= 1'b1;
                            r_db_cnt    <= '0;
                        end else begin
                            r_db_cnt <= f_sat_inc(r_db_cnt);
                        end
                    end else begin
                        // Bounce: give up on this row and move on.
                        r_state   <= SCAN;
                        r_db_cnt  <= '0;
                        r_div_cnt <= '0;
                        r_row_idx <= r_row_idx + 2'd1;
                        r_rows    <= {r_rows[2:0], r_rows[3]};
                    end
                end
                HELD: begin
                    if (w_all_high) begin
                        r_state  <= RELEASE;
                        r_db_cnt <= '0;
                    end
                end
                RELEASE: begin
                    if (w_all_high) begin
                        if (r_db_cnt >= c_DB_LAST) begin
                            r_state    <= SCAN;
                            r_key_held <= 1'b0;
                            r_db_cnt   <= '0;
                            r_div_cnt  <= '0;
                            r_row_idx  <= r_row_idx + 2'd1;
                            r_rows     <= {r_rows[2:0], r_rows[3]};
                        end else begin
                            r_db_cnt <= f_sat_inc(r_db_cnt);
                        end
                    end else begin
                        r_state  <= HELD;
                        r_db_cnt <= '0;
                    end
                end
                default: r_state <= SCAN;
            endcase
        end
    end

    assign o_rows      = r_rows;
    assign o_key       = r_key;
    assign o_key_valid = r_key_valid;
    assign o_key_held  = r_key_held;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// tb_keypad_scanner: keypad matrix model drives cols from rows; a cycle-level
// behavioural model of the scanner is compared against the DUT every cycle.
module tb_keypad_scanner;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 8;
    localparam int M_SCAN = 0, M_DEB = 1, M_HELD = 2, M_REL = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] press = '0;    // bit row*4+col set = key physically down
    logic [3:0]  w_cols, w_rows, w_key;
    logic        w_valid, w_held;

    int n_checks = 0;
    int n_err    = 0;
    int n_pulses = 0;
    logic [3:0] pulse_key = 4'h0;
    bit prev_valid = 1'b0;

    string KEYS = "123A456B789CE0FD";

    always #5 clk = ~clk;

    function automatic logic [3:0] f_cols(input logic [3:0] rows, input logic [15:0] p);
        logic [3:0] c;
        c = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!rows[r])
                for (int k = 0; k < 4; k++)
                    if (p[r*4+k]) c[k] = 1'b0;
        return c;
    endfunction

    function automatic logic [3:0] f_hex(input byte ch);
        if (ch >= "0" && ch <= "9") return 4'(ch - "0");
        return 4'(ch - "A" + 10);
    endfunction

    assign w_cols = f_cols(w_rows, press);

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_cols      (w_cols),
        .o_rows      (w_rows),
        .o_key       (w_key),
        .o_key_valid (w_valid),
        .o_key_held  (w_held)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the scanner sees the column lines two clocks late.
    int         m_mode, m_row, m_pos, m_stable;
    logic [3:0] m_pat, m_key, h1, h2;
    bit         m_valid, m_held;

    always @(posedge clk or negedge rst_n) begin
        logic [3:0] cs, now_cols;
        int nlow, col;
        if (!rst_n) begin
            m_mode = M_SCAN; m_row = 0; m_pos = 0; m_stable = 0;
            m_pat = 4'hF; m_key = 4'h0; m_valid = 0; m_held = 0;
            h1 = 4'hF; h2 = 4'hF;
        end else begin
            now_cols = f_cols(~(4'b0001 << m_row), press);
            cs = h2;
            nlow = 0; col = 0;
            for (int k = 0; k < 4; k++)
                if (!cs[k]) begin nlow++; col = k; end
            m_valid = 0;
            case (m_mode)
                M_SCAN: begin
                    if (m_pos == SCAN_DIV - 1) begin
                        m_pos = 0;
                        if (nlow == 1) begin
                            m_mode = M_DEB; m_pat = cs; m_stable = 0;
                        end else m_row = (m_row + 1) % 4;
                    end else m_pos++;
                end
                M_DEB: begin
                    if (cs == m_pat) begin
                        m_stable++;
                        if (m_stable == DEBOUNCE_CNT) begin
                            for (int k = 0; k < 4; k++) if (!m_pat[k]) col = k;
                            m_key = f_hex(KEYS[m_row*4+col]);
                            m_valid = 1; m_held = 1; m_mode = M_HELD;
                        end
                    end else begin
                        m_mode = M_SCAN; m_row = (m_row + 1) % 4; m_pos = 0;
                    end
                end
                M_HELD: begin
                    if (cs == 4'hF) begin m_mode = M_REL; m_stable = 0; end
                end
                default: begin
                    if (cs == 4'hF) begin
                        m_stable++;
                        if (m_stable == DEBOUNCE_CNT) begin
                            m_mode = M_SCAN; m_held = 0; m_row = (m_row + 1) % 4; m_pos = 0;
                        end
                    end else m_mode = M_HELD;
                end
            endcase
            h2 = h1;
            h1 = now_cols;
        end
    end

    always @(negedge clk) begin
        logic [3:0] er;
        er = ~(4'b0001 << m_row);
        chk("rows", w_rows, er);
        chk("key", w_key, m_key);
        chk("key_valid", w_valid, m_valid);
        chk("key_held", w_held, m_held);
        if (prev_valid) chk("valid_back_to_back", w_valid, 0);
        if (w_valid) begin n_pulses++; pulse_key = w_key; end
        prev_valid = w_valid;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_released(input string name);
        int t;
        t = 0;
        while (w_held && t < 60) begin cyc(1); t++; end
        chk({name, "_release_timeout"}, w_held, 0);
    endtask

    initial begin
        int base, hc, t;
        logic [3:0] er;
        cyc(3);
        chk("rst_rows", w_rows, 4'b1110);
        chk("rst_key", w_key, 4'h0);
        chk("rst_valid", w_valid, 0);
        chk("rst_held", w_held, 0);
        rst_n = 1'b1;

        // Idle scan: row index = (cycles/4) mod 4
        for (int n = 0; n < 64; n++) begin
            er = ~(4'b0001 << ((n / 4) % 4));
            chk("idle_rows", w_rows, er);
            chk("idle_valid", w_valid, 0);
            cyc(1);
        end

        // Key 6, held 40 cycles
        base = n_pulses;
        press[1*4+2] = 1'b1;
        cyc(40);
        chk("k6_pulses", n_pulses - base, 1);
        chk("k6_key", pulse_key, 4'h6);
        chk("k6_held", w_held, 1);
        press = '0;
        hc = 0;
        for (int i = 0; i < 30; i++) begin cyc(1); if (w_held) hc++; end
        chk("k6_release_latency", hc, 10);

        // Key 9 bouncing every 3 cycles, then stable
        base = n_pulses;
        for (int i = 0; i < 10; i++) begin
            press[2*4+2] = (i % 2 == 0);
            cyc(3);
        end
        chk("k9_bounce_pulses", n_pulses - base, 0);
        press[2*4+2] = 1'b1;
        cyc(40);
        chk("k9_pulses", n_pulses - base, 1);
        chk("k9_key", pulse_key, 4'h9);
        press = '0;
        wait_released("k9");

        // D held, 1 pressed as well, then D released
        base = n_pulses;
        press[3*4+3] = 1'b1;
        t = 0;
        while (n_pulses == base && t < 40) begin cyc(1); t++; end
        chk("kD_pulses", n_pulses - base, 1);
        chk("kD_key", pulse_key, 4'hD);
        press[0] = 1'b1;
        cyc(30);
        chk("kD_second_pulse", n_pulses - base, 1);
        chk("kD_still_held", w_held, 1);
        press[3*4+3] = 1'b0;
        cyc(60);
        chk("k1_pulses", n_pulses - base, 2);
        chk("k1_key", pulse_key, 4'h1);
        press = '0;
        wait_released("k1");

        // Two columns low in one row
        base = n_pulses;
        press[2*4+0] = 1'b1;
        press[2*4+1] = 1'b1;
        cyc(40);
        chk("dual_pulses", n_pulses - base, 0);
        chk("dual_held", w_held, 0);
        press = '0;
        cyc(4);

        // Reset during debounce of A
        base = n_pulses;
        press[0*4+3] = 1'b1;
        t = 0;
        while (m_mode != M_DEB && t < 40) begin cyc(1); t++; end
        chk("kA_reached_debounce", m_mode, M_DEB);
        cyc(2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("kA_rst_rows", w_rows, 4'b1110);
        chk("kA_rst_key", w_key, 4'h0);
        chk("kA_rst_valid", w_valid, 0);
        chk("kA_rst_held", w_held, 0);
        cyc(1);
        press = '0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        chk("kA_first_rows", w_rows, 4'b1110);
        cyc(30);
        chk("kA_pulses", n_pulses - base, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 10000: clk cycles each row is driven before the scan advances.
REQ-002 Parameter DEBOUNCE_CNT, default 50000: consecutive stable clk cycles needed to accept a press or a release.
REQ-003 clk  input  1  single system clock; all state on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cols  input  4  keypad column lines; active-low; pulled up; asynchronous to clk.
REQ-006 rows  output  4  keypad row drives; active-low; exactly one bit low at all times.
REQ-007 key  output  4  hex code of the last accepted key.
REQ-008 key_valid  output  1  one-cycle pulse when a new key is accepted.
REQ-009 key_held  output  1  high from key acceptance until release is accepted.

Function
REQ-010 cols SHALL pass through a 2-flop synchronizer; all logic uses only the synchronized value (cs).
REQ-011 FSM states SHALL be SCAN, DEBOUNCE, HELD and RELEASE.
REQ-012 SCAN: the row index (0..3) SHALL advance every SCAN_DIV cycles and wrap 3->0; rows = ~(4'b0001 << index).
REQ-013 SCAN: cs SHALL be sampled only on the last cycle of each row slot; exactly one cs bit low -> DEBOUNCE, latch row/col, row frozen; zero or multiple bits low -> keep scanning.
REQ-014 DEBOUNCE: counter SHALL increment each cycle cs equals the latched single-low pattern; any mismatch -> SCAN with the row index advanced, counter cleared, no output change.
REQ-015 DEBOUNCE: when counter reaches DEBOUNCE_CNT-1 with a match, the next cycle SHALL enter HELD, load key, pulse key_valid, and set key_held.
REQ-016 Key map [row][col] SHALL be: r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = E,0,F,D.
REQ-017 HELD: row SHALL stay frozen; cs all high -> RELEASE with counter cleared; other keys in other rows or columns are ignored.
REQ-018 RELEASE: counter SHALL increment while cs is all high; any low bit -> HELD, counter cleared, no new key_valid.
REQ-019 RELEASE: after DEBOUNCE_CNT consecutive all-high cycles -> SCAN, key_held deasserts, row index advances; key keeps its last value.
REQ-020 key_valid SHALL never be high on two consecutive cycles; at most one pulse per physical press.
REQ-021 Counters SHALL be $clog2 of the larger parameter wide and SHALL saturate rather than wrap.

Reset
REQ-022 While reset is low: rows = 4'b1110, key = 4'h0, key_valid = 0, key_held = 0, state = SCAN, row index 0, counters 0, synchronizer flops 1s.
REQ-023 Reset asserted mid-press or mid-debounce SHALL abort immediately; after release, scanning restarts at row 0 and no key_valid is emitted for the aborted press.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8)
REQ-024 No keys pressed for 64 cycles after reset -> rows cycle 1110,1101,1011,0111 every 4 cycles; key_valid never high.
REQ-025 Hold key "6" (row1, cols=4'b1011 while rows=1101) for 40 cycles, then release -> one key_valid pulse with key=4'h6; key_held high until 8 cycles after release plus sync latency.
REQ-026 Key "9" bounces low/high every 3 cycles for 30 cycles, then stays stable -> no key_valid during bounce; exactly one pulse (key=4'h9) after 8 stable cycles.
REQ-027 While "D" is held, press "1" too, then release "D" -> no second pulse while held; after debounced release, "1" is accepted on a later scan with key=4'h1.
REQ-028 Two columns low in one row (cols=4'b1100) -> treated as no press; scan continues; no key_valid.
REQ-029 Assert reset during DEBOUNCE of "A" -> outputs return to reset values asynchronously; no key_valid; rows=1110 on the first cycle after deassertion.
